serial_adder_ctrl: RTL

// Sequences one full_adder cell to add two WIDTH-bit operands bit-serially, LSB first.
// - Captures operands on a start request.
// - Drives the cell one bit per clock, holding the running carry in a flop.
// - Returns sum and carry-out with a one-cycle done pulse.
// - Sits between a requesting datapath/testbench and the shared full_adder cell.
//

---
 rtl/serial_adder_ctrl_pkg.sv | 17 +
 rtl/serial_adder_ctrl_full_adder.sv | 17 +
 rtl/serial_adder_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types for the bit-serial adder controller.
// State encoding is fixed; code 2'd3 is unused and decodes back to S_IDLE.
package serial_adder_ctrl_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder cell, purely combinational.
// Shared by the serial controller; no state, no backpressure.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic p;

   assign p    = a ^ b;
   assign sum  = p ^ cin;
   assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: start accepted at edge E, result and done after edge E+WIDTH.
// start is ignored while busy; a new operation can begin every WIDTH+2 edges.
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] s_sh_q, s_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             fa_sum;
   logic             fa_cout;
   logic [WIDTH-1:0] s_shifted;
   logic             accept;
   logic             last_bit;

   full_adder u_fa (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB.
   generate
      if (WIDTH == 1) begin : g_sh1
         assign s_shifted = fa_sum;
      end else begin : g_shn
         assign s_shifted = {fa_sum, s_sh_q[WIDTH-1:1]};
      end
   endgenerate

   assign accept   = (state_q == S_IDLE) && start;
   assign last_bit = (state_q == S_ADD) && (cnt_q == CNT_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = S_IDLE;
      case (state_q)
         S_IDLE:  state_d = start ? S_ADD : S_IDLE;
         S_ADD:   state_d = (cnt_q == CNT_LAST) ? S_DONE : S_ADD;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         S_ADD:   busy = 1'b1;
         S_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   // Datapath next values
   always_comb begin
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      s_sh_d  = s_sh_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      if (accept) begin
         a_sh_d  = op_a;
         b_sh_d  = op_b;
         carry_d = cin;
         cnt_d   = '0;
      end else if (state_q == S_ADD) begin
         a_sh_d  = a_sh_q >> 1;
         b_sh_d  = b_sh_q >> 1;
         s_sh_d  = s_shifted;
         carry_d = fa_cout;
         cnt_d   = cnt_q + 1'b1;
      end
      if (last_bit) begin
         sum_d  = s_shifted;
         cout_d = fa_cout;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         s_sh_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         s_sh_q  <= s_sh_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule
